// File: rtl/count_event_monitor.sv
// count_event_monitor: watches the free-running counter's count value and
// queues timestamped records for compare-match, wrap-around and (optionally)
// discontinuity events in a small first-word-fall-through FIFO that drains
// through a valid/ready interface.
// Optional feature macro: COUNT_EVT_JUMP_EN enables JUMP (discontinuity)
// detection; when undefined evt_flags[2] is always 0.
module count_event_monitor #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int STAMP_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   count_in,
  input  logic [WIDTH-1:0]   cmp_val,
  input  logic               cmp_arm,
  input  logic               clear,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [2:0]         evt_flags,
  output logic [STAMP_W-1:0] evt_stamp,
  output logic [WIDTH-1:0]   evt_count,
  output logic               overflow,
  output logic               armed
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FIRED = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [WIDTH-1:0]   prev_count_q;
  logic               prev_valid_q;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;

  // Record storage carries no reset; the head is gated by evt_valid instead.
  logic [2:0]         flags_mem_q [DEPTH];
  logic [STAMP_W-1:0] stamp_mem_q [DEPTH];
  logic [WIDTH-1:0]   count_mem_q [DEPTH];

  logic       hit_match, hit_wrap, hit_jump;
  logic [2:0] det_flags;
  logic       push, pop, push_ok, full, empty;

`ifdef COUNT_EVT_JUMP_EN
  logic [WIDTH-1:0] prev_inc;
  assign prev_inc = prev_count_q + WIDTH'(1);
  // A step other than hold or +1 is a discontinuity; FF->00 counts as +1.
  assign hit_jump = prev_valid_q && (count_in != prev_count_q) && (count_in != prev_inc);
`else
  assign hit_jump = 1'b0;
`endif

  // Event detection against the previous sample; match fires only on entry.
  always_comb begin
    hit_wrap  = prev_valid_q && (prev_count_q == '1) && (count_in == '0);
    hit_match = (state_q == ARMED) && (count_in == cmp_val) && (count_in != prev_count_q);
    det_flags = {hit_jump, hit_wrap, hit_match};
  end

  // FIFO handshake: a full FIFO still accepts a push when the head pops.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop     = !empty && evt_ready;
    push    = (|det_flags) && !clear;
    push_ok = push && (!full || pop);
  end

  // Next-state for pointers, sticky overflow and free-running timestamp.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    stamp_d    = stamp_q + STAMP_W'(1);
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok)          wr_ptr_d   = wr_ptr_q + PTR_ONE;
      if (pop)              rd_ptr_d   = rd_ptr_q + PTR_ONE;
      if (push && !push_ok) overflow_d = 1'b1;
    end
  end

  // Compare FSM next state; clear dominates any arm request.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cmp_arm)   state_d = ARMED;
        ARMED:   if (hit_match) state_d = FIRED;
        FIRED:   if (cmp_arm)   state_d = ARMED;
        default:                state_d = IDLE;
      endcase
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      stamp_q      <= '0;
      prev_count_q <= '0;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stamp_q      <= stamp_d;
      prev_count_q <= count_in;
      prev_valid_q <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
    end
  end

  // Record write into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      flags_mem_q[wr_ptr_q[AW-1:0]] <= det_flags;
      stamp_mem_q[wr_ptr_q[AW-1:0]] <= stamp_q;
      count_mem_q[wr_ptr_q[AW-1:0]] <= count_in;
    end
  end

  assign evt_valid = !empty;
  assign evt_flags = evt_valid ? flags_mem_q[rd_ptr_q[AW-1:0]] : 3'b000;
  assign evt_stamp = evt_valid ? stamp_mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign evt_count = evt_valid ? count_mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign overflow  = overflow_q;
  assign armed     = (state_q == ARMED);

endmodule

// File: tb/tb_count_event_monitor.sv
// Scoreboard bench for count_event_monitor: expected records are queued as
// stimulus is driven and compared as the DUT presents them on the output.
module tb_count_event_monitor;

  localparam int DEPTH = 4;
  localparam logic [2:0] MF = 3'b001;
  localparam logic [2:0] WF = 3'b010;
`ifdef COUNT_EVT_JUMP_EN
  localparam logic [2:0] JF = 3'b100;
`else
  localparam logic [2:0] JF = 3'b000;
`endif

  typedef struct packed {
    logic [2:0]  flags;
    logic [15:0] stamp;
    logic [7:0]  cnt;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  count_in = '0;
  logic [7:0]  cmp_val = '0;
  logic        cmp_arm = 1'b0;
  logic        clear = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [2:0]  evt_flags;
  logic [15:0] evt_stamp;
  logic [7:0]  evt_count;
  logic        overflow;
  logic        armed;

  rec_t        exp_q[$];
  rec_t        mon_e;
  logic [15:0] tb_stamp;
  int          total = 0;
  int          bad = 0;

  count_event_monitor #(.WIDTH(8), .DEPTH(DEPTH), .STAMP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .cmp_val(cmp_val),
    .cmp_arm(cmp_arm), .clear(clear), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_flags(evt_flags), .evt_stamp(evt_stamp),
    .evt_count(evt_count), .overflow(overflow), .armed(armed)
  );

  always #5 clk = ~clk;

  // Reference timestamp: cycles since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_stamp <= '0;
    else        tb_stamp <= tb_stamp + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs; queue the record the DUT should accept.
  task automatic drive(input logic [7:0] c, input logic [2:0] ef, input logic arm, input logic clr);
    rec_t r;
    @(posedge clk); #1;
    count_in = c;
    cmp_arm  = arm;
    clear    = clr;
    if (ef != 3'b000 && !clr && exp_q.size() < DEPTH) begin
      r.flags = ef;
      r.stamp = tb_stamp;
      r.cnt   = c;
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Output monitor: each accepted head record is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rec", 32'(evt_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rec_flags", 32'(evt_flags), 32'(mon_e.flags));
        chk("rec_stamp", 32'(evt_stamp), 32'(mon_e.stamp));
        chk("rec_count", 32'(evt_count), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset with count held at 0.
    repeat (10) @(posedge clk);
    #1;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_armed", 32'(armed), 0);
    rst_n = 1'b1;
    drive(8'h00, 3'b000, 1'b0, 1'b0);
    drive(8'h00, 3'b000, 1'b0, 1'b0);
    drive(8'h00, 3'b000, 1'b0, 1'b0);
    chk("t1_valid", 32'(evt_valid), 0);

    // Test 2: armed compare on a ramp.
    cmp_val = 8'h05;
    drive(8'h00, 3'b000, 1'b1, 1'b0);
    drive(8'h00, 3'b000, 1'b0, 1'b0);
    chk("t2_armed", 32'(armed), 1);
    for (int i = 0; i <= 10; i++) begin
      drive(8'(i), (i == 5) ? MF : 3'b000, 1'b0, 1'b0);
      if (i == 6) begin
        chk("t2_valid_lat", 32'(evt_valid), 1);
        chk("t2_disarm", 32'(armed), 0);
      end
    end
    wait_drain(10);

    // Test 3: wrap coinciding with a match at 0.
    cmp_val = 8'h00;
    drive(8'hFD, JF, 1'b0, 1'b0);
    drive(8'hFD, 3'b000, 1'b1, 1'b0);
    drive(8'hFE, 3'b000, 1'b0, 1'b0);
    chk("t3_armed", 32'(armed), 1);
    drive(8'hFF, 3'b000, 1'b0, 1'b0);
    drive(8'h00, MF | WF, 1'b0, 1'b0);
    drive(8'h01, 3'b000, 1'b0, 1'b0);
    chk("t3_disarm", 32'(armed), 0);
    drive(8'h02, 3'b000, 1'b0, 1'b0);
    wait_drain(10);
    drive(8'h02, 3'b000, 1'b1, 1'b1);
    drive(8'h02, 3'b000, 1'b0, 1'b0);
    chk("arm_vs_clear", 32'(armed), 0);

    // Test 4: overflow with consumer stalled, then ordered drain and clear.
    drive(8'hFF, JF, 1'b0, 1'b0);
    drive(8'hFF, 3'b000, 1'b0, 1'b0);
    wait_drain(10);
    evt_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(8'h00, WF, 1'b0, 1'b0);
      drive(8'hFF, JF, 1'b0, 1'b0);
    end
    drive(8'hFF, 3'b000, 1'b0, 1'b0);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_valid", 32'(evt_valid), 1);
    chk("t4_hold_count", 32'(evt_count), 32'(exp_q[0].cnt));
    drive(8'hFF, 3'b000, 1'b0, 1'b0);
    chk("t4_hold_stamp", 32'(evt_stamp), 32'(exp_q[0].stamp));
    evt_ready = 1'b1;
    wait_drain(20);
    chk("t4_sticky", 32'(overflow), 1);
    chk("t4_empty", 32'(evt_valid), 0);
    drive(8'h00, WF, 1'b0, 1'b1);
    drive(8'h00, 3'b000, 1'b0, 1'b0);
    chk("clr_overflow", 32'(overflow), 0);
    chk("clr_valid", 32'(evt_valid), 0);

    // Test 5: discontinuity 3 -> 9.
    drive(8'h01, 3'b000, 1'b0, 1'b0);
    drive(8'h02, 3'b000, 1'b0, 1'b0);
    drive(8'h03, 3'b000, 1'b0, 1'b0);
    drive(8'h09, JF, 1'b0, 1'b0);
    drive(8'h0A, 3'b000, 1'b0, 1'b0);
    chk("t5_valid", 32'(evt_valid), 32'(JF != 3'b000));
    wait_drain(10);

    // Test 6: asynchronous reset mid-drain.
    evt_ready = 1'b0;
    drive(8'hFF, JF, 1'b0, 1'b0);
    drive(8'h00, WF, 1'b0, 1'b0);
    drive(8'hFF, JF, 1'b0, 1'b0);
    drive(8'h00, WF, 1'b0, 1'b0);
    drive(8'h00, 3'b000, 1'b0, 1'b0);
    chk("t6_valid", 32'(evt_valid), 1);
    evt_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(evt_valid), 0);
    chk("t6_rst_armed", 32'(armed), 0);
    exp_q.delete();
    count_in = 8'h50;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(8'h50, 3'b000, 1'b0, 1'b0);
    drive(8'h50, 3'b000, 1'b0, 1'b0);
    drive(8'h51, 3'b000, 1'b0, 1'b0);
    chk("t6_no_spurious", 32'(evt_valid), 0);
    chk("t6_overflow", 32'(overflow), 0);
    drive(8'h52, 3'b000, 1'b0, 1'b0);
    wait_drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream consumer of the free-running `counter` block: samples its `count` output every clock and detects compare-match, wrap-around and discontinuity events.
- Each event is queued as a timestamped record in a small FIFO.
- Records drain through a valid/ready interface to a logger or interrupt stage.

Parameters:
- WIDTH, 8, width of the monitored count; must match the counter's WIDTH.
- DEPTH, 4, event FIFO entries; power of two, minimum 2.
- STAMP_W, 16, timestamp width in bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- count_in  input  WIDTH  counter value, sampled every posedge
- cmp_val  input  WIDTH  compare value, sampled every posedge
- cmp_arm  input  1  one-cycle pulse, arms compare
- clear  input  1  synchronous flush: FIFO, overflow, arm FSM
- evt_valid  output  1  head record available
- evt_ready  input  1  consumer accepts head record
- evt_flags  output  3  head record flags: [0] MATCH, [1] WRAP, [2] JUMP
- evt_stamp  output  STAMP_W  head record timestamp
- evt_count  output  WIDTH  count_in value at detection
- overflow  output  1  sticky: a record was dropped
- armed  output  1  compare FSM is in ARMED

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0, FIFO empty, prev_count=0, prev_valid=0, stamp counter=0, FSM=IDLE.
  - Takes effect immediately, mid-transfer included; any in-flight record is discarded.
- Stamp counter: increments every cycle, wraps at 2^STAMP_W-1 -> 0. clear does not affect it.
- History: every posedge, prev_count<=count_in and prev_valid<=1. clear does not affect history.
- Event detection at posedge t compares count_in(t) against prev_count:
  - WRAP: prev_valid, prev_count = all ones, count_in = 0.
  - MATCH: FSM=ARMED, count_in == cmp_val, count_in != prev_count (entry into value only, not while held).
  - JUMP: prev_valid, count_in != prev_count, count_in != prev_count+1 mod 2^WIDTH.
  - All three flags evaluated independently; any set -> one record pushed with all applicable flags.
  - First cycle after reset (prev_valid=0) yields no WRAP/JUMP.
- Compare FSM:
  - IDLE -(cmp_arm)-> ARMED -(MATCH)-> FIRED.
  - FIRED -(cmp_arm)-> ARMED. clear -> IDLE from any state.
  - cmp_arm while ARMED: no effect. cmp_arm with clear same cycle: clear wins.
  - armed = (state==ARMED).
- FIFO (first-word-fall-through):
  - record written at posedge t; evt_valid high from cycle t+1. Latency is 1 cycle into an empty FIFO.
  - pop on posedge when evt_valid && evt_ready.
  - push when full without simultaneous pop: record dropped, overflow<=1. push+pop when full: both accepted, no drop.
  - push+pop when empty: record written, no pop; empty FIFO has evt_valid=0.
  - evt_flags/evt_stamp/evt_count stable while evt_valid && !evt_ready.
  - Pointers wrap modulo DEPTH; full/empty via extra pointer bit.
- clear:
  - empties FIFO and clears overflow at the next posedge.
  - an event detected in the clear cycle is discarded.
  - evt_valid=0 the cycle after.

Optional Feature:
- COUNT_EVT_JUMP_EN defined: JUMP detection active as above.
- Not defined: JUMP logic omitted, evt_flags[2] tied 0, discontinuities produce no record.

Test Plan:
1. Reset 10 cycles, count_in held 0 -> no records, evt_valid=0, overflow=0, armed=0.
2. cmp_val=8'h05, pulse cmp_arm, count_in ramps 0..10, evt_ready=1 -> exactly one record: flags=3'b001, evt_count=5, evt_valid one cycle after count_in=5, armed drops to 0.
3. count_in ramps 8'hFD..8'h02 with cmp_val=0, armed -> one record: flags=3'b011, evt_count=0; stamp equals stamp counter at detection.
4. evt_ready=0; five WRAP events (count_in toggled FF->00 five times) with DEPTH=4 -> 4 records held, overflow=1. Then evt_ready=1 -> 4 pops in order, stamps increasing; clear -> overflow=0.
5. count_in 3 -> 9 jump (macro defined) -> flags=3'b100, evt_count=9. Macro undefined -> no record.
6. rst_n low mid-drain with 2 records queued -> evt_valid=0 immediately. After release, no spurious WRAP/JUMP on first sample.
